sig_relay_pipe: RTL

//  Parametrised multi-channel signal relay; next generation of the 1-bit combinational pass-through.

---
 rtl/sig_relay_pipe_pkg.sv | 11 +
 rtl/sig_relay_pipe_if.sv | 25 ++
 rtl/sig_relay_pipe_skid_slice.sv | 91 +++++++++
 rtl/sig_relay_pipe.sv | 59 +++++
 4 files changed

// File: rtl/sig_relay_pipe_pkg.sv
// Shared types for the multi-channel signal relay.
package sig_relay_pipe_pkg;

    // Occupancy of one skid slice: nothing, main register only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } slice_state_e;

endpackage

// File: rtl/sig_relay_pipe_if.sv
// Bundled per-channel valid/ready streams for the relay, producer and consumer sides.
interface sig_relay_pipe_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 1
);
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ready;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       busy;

    // Environment side: drives producer data and consumer ready.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    // Relay side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/sig_relay_pipe_skid_slice.sv
// One registered skid stage for a single channel.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  EMPTY | no beat held; main and skid registers free
//  FULL  | one beat in main register, presented downstream
//  SKID  | main presented downstream and stalled, second beat parked in skid
//
// up_ready comes straight from the state register, so no ready path runs
// combinationally through the slice. flush only masks the handshakes for the
// cycle in which everything is being dropped.
module relay_skid_slice
    import sig_relay_pipe_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_data,
    output logic             main_valid
);

    slice_state_e     state_q;
    slice_state_e     state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             up_xfer;
    logic             down_xfer;

    assign up_xfer   = up_valid & up_ready;
    assign down_xfer = down_valid & down_ready;
    assign down_data = main_q;

    // State register; reset and flush clear identically, reset simply wins when both are set.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode from the two handshakes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (up_xfer) state_d = FULL;
            end
            FULL: begin
                if (up_xfer && !down_xfer)      state_d = SKID;
                else if (!up_xfer && down_xfer) state_d = EMPTY;
            end
            SKID: begin
                if (down_xfer) state_d = FULL;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Handshake outputs from the registered state, masked while flushing.
    always_comb begin
        main_valid = (state_q != EMPTY);
        up_ready   = (state_q != SKID) && !flush;
        down_valid = (state_q != EMPTY) && !flush;
    end

    // Payload registers: main takes new data or the parked skid beat; skid catches a stalled arrival.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (state_q == SKID) begin
                if (down_xfer) main_q <= skid_q;
            end else if (up_xfer && ((state_q == EMPTY) || down_xfer)) begin
                main_q <= up_data;
            end
            if ((state_q == FULL) && up_xfer && !down_xfer) begin
                skid_q <= up_data;
            end
        end
    end

endmodule

// File: rtl/sig_relay_pipe.sv
// Multi-channel valid/ready relay: CHANNELS independent streams, each retimed
// through DEPTH skid slices. DEPTH=0 is a plain wire relay with no state.
module sig_relay_pipe
    import sig_relay_pipe_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 1,
    parameter int DEPTH    = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    sig_relay_pipe_if.slave  bus
);

    if (DEPTH == 0) begin : g_bypass
        // clock, reset and flush have no role when there are no slices.
        logic bypass_unused;
        assign bypass_unused = ^{clock, reset, flush};

        assign bus.out_valid = bus.in_valid;
        assign bus.out_data  = bus.in_data;
        assign bus.in_ready  = bus.out_ready;
        assign bus.busy      = '0;
    end else begin : g_pipe
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic [DEPTH:0]            vld;
            logic [DEPTH:0]            rdy;
            logic [DEPTH:0][WIDTH-1:0] dat;
            logic [DEPTH-1:0]          occ;

            assign vld[0]                          = bus.in_valid[c];
            assign dat[0]                          = bus.in_data[c*WIDTH +: WIDTH];
            assign bus.in_ready[c]                 = rdy[0];
            assign bus.out_valid[c]                = vld[DEPTH];
            assign bus.out_data[c*WIDTH +: WIDTH]  = dat[DEPTH];
            assign rdy[DEPTH]                      = bus.out_ready[c];
            assign bus.busy[c]                     = |occ;

            for (genvar s = 0; s < DEPTH; s++) begin : g_slice
                relay_skid_slice #(
                    .WIDTH (WIDTH)
                ) u_slice (
                    .clock      (clock),
                    .reset      (reset),
                    .flush      (flush),
                    .up_valid   (vld[s]),
                    .up_ready   (rdy[s]),
                    .up_data    (dat[s]),
                    .down_valid (vld[s+1]),
                    .down_ready (rdy[s+1]),
                    .down_data  (dat[s+1]),
                    .main_valid (occ[s])
                );
            end
        end
    end

endmodule
